// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: fetches from sync instruction memory at pc_count, resolves
// JMP/JZ/HLT locally and issues everything else to execute over valid/ready.
module fetch_ctrl #(
  parameter int AW = 5,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] pc_count,
  output logic          pc_en,
  output logic          pc_load,
  output logic [AW-1:0] pc_data,
  output logic [AW-1:0] imem_addr,
  output logic          imem_ren,
  input  logic [DW-1:0] imem_rdata,
  input  logic          zero_flag,
  output logic          instr_valid,
  input  logic          instr_ready,
  output logic [2:0]    instr_opcode,
  output logic [AW-1:0] instr_operand,
  output logic [AW-1:0] instr_pc,
  output logic          halted
);

  localparam logic [2:0] OP_HLT = 3'b000;
  localparam logic [2:0] OP_JZ  = 3'b110;
  localparam logic [2:0] OP_JMP = 3'b111;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    ISSUE  = 3'd3,
    UPDATE = 3'd4,
    HALT   = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    op_q;
  logic [AW-1:0] opd_q;
  logic [AW-1:0] ipc_q;
  logic          zf_q;

  logic [2:0]    rdata_op;
  logic          take_jump;

  assign rdata_op  = imem_rdata[DW-1:DW-3];
  // JZ uses the zero flag captured in DECODE, not the live flag in UPDATE.
  assign take_jump = (op_q == OP_JMP) || ((op_q == OP_JZ) && zf_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      opd_q   <= '0;
      ipc_q   <= '0;
      zf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == DECODE) begin
        op_q  <= rdata_op;
        opd_q <= imem_rdata[AW-1:0];
        ipc_q <= pc_count;
        zf_q  <= zero_flag;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_en         = 1'b0;
    pc_load       = 1'b0;
    pc_data       = '0;
    imem_addr     = '0;
    imem_ren      = 1'b0;
    instr_valid   = 1'b0;
    instr_opcode  = '0;
    instr_operand = '0;
    instr_pc      = '0;
    halted        = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = FETCH;
      end
      FETCH: begin
        imem_addr = pc_count;
        imem_ren  = 1'b1;
        state_d   = DECODE;
      end
      DECODE: begin
        if (rdata_op == OP_HLT)
          state_d = HALT;
        else if ((rdata_op == OP_JMP) || (rdata_op == OP_JZ))
          state_d = UPDATE;
        else
          state_d = ISSUE;
      end
      ISSUE: begin
        instr_valid   = 1'b1;
        instr_opcode  = op_q;
        instr_operand = opd_q;
        instr_pc      = ipc_q;
        if (instr_ready) state_d = UPDATE;
      end
      UPDATE: begin
        if (take_jump) begin
          pc_load = 1'b1;
          pc_data = opd_q;
        end else begin
          pc_en = 1'b1;
        end
        state_d = FETCH;
      end
      HALT: begin
        halted = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a behavioural PC block and synchronous instruction ROM.
module tb_fetch_ctrl;
  localparam int AW = 5;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] pc_count;
  logic          pc_en, pc_load;
  logic [AW-1:0] pc_data;
  logic [AW-1:0] imem_addr;
  logic          imem_ren;
  logic [DW-1:0] imem_rdata;
  logic          zero_flag;
  logic          instr_valid;
  logic          instr_ready;
  logic [2:0]    instr_opcode;
  logic [AW-1:0] instr_operand;
  logic [AW-1:0] instr_pc;
  logic          halted;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic          pc_rst;
  logic [AW-1:0] pc_rst_val;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // PC block model: separate reset, load has priority over increment.
  always @(posedge clk) begin
    if (pc_rst)       pc_count <= pc_rst_val;
    else if (pc_load) pc_count <= pc_data;
    else if (pc_en)   pc_count <= pc_count + 1'b1;
  end

  always @(posedge clk) begin
    if (imem_ren) imem_rdata <= mem[imem_addr];
  end

  fetch_ctrl #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .pc_count(pc_count),
    .pc_en(pc_en), .pc_load(pc_load), .pc_data(pc_data),
    .imem_addr(imem_addr), .imem_ren(imem_ren), .imem_rdata(imem_rdata),
    .zero_flag(zero_flag), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_opcode(instr_opcode), .instr_operand(instr_operand), .instr_pc(instr_pc),
    .halted(halted)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; zero_flag = 1'b0; instr_ready = 1'b0;
    pc_rst = 1'b1; pc_rst_val = '0;
    tick(); tick();
    n_cmp++;
    if ({pc_en, pc_load, pc_data, imem_addr, imem_ren, instr_valid, instr_opcode,
         instr_operand, instr_pc, halted} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got en=%b ld=%b pd=%0d ia=%0d ren=%b v=%b op=%0d opd=%0d ipc=%0d h=%b required all 0",
               pc_en, pc_load, pc_data, imem_addr, imem_ren, instr_valid, instr_opcode,
               instr_operand, instr_pc, halted);
    end
    rst = 1'b1; pc_rst = 1'b0;
    tick();
    n_cmp++;
    if (imem_ren !== 1'b0) begin
      n_err++; $display("FAIL reset_idle_no_fetch: imem_ren=%b required 0", imem_ren);
    end
    $display("test_reset done");
  endtask

  task automatic test_execute();
    instr_ready = 1'b1;
    start = 1'b1;
    tick();                               // -> FETCH
    start = 1'b0;
    n_cmp++;
    if (imem_ren !== 1'b1 || imem_addr !== 5'd0) begin
      n_err++; $display("FAIL exec_fetch: ren=%b addr=%0d required ren=1 addr=0", imem_ren, imem_addr);
    end
    tick();                               // -> DECODE
    n_cmp++;
    if (instr_valid !== 1'b0) begin
      n_err++; $display("FAIL exec_decode_valid: instr_valid=%b required 0", instr_valid);
    end
    tick();                               // -> ISSUE
    n_cmp++;
    if (instr_valid !== 1'b1 || instr_opcode !== 3'd1 || instr_operand !== 5'd5 || instr_pc !== 5'd0) begin
      n_err++;
      $display("FAIL exec_issue: v=%b op=%0d opd=%0d pc=%0d required v=1 op=1 opd=5 pc=0",
               instr_valid, instr_opcode, instr_operand, instr_pc);
    end
    tick();                               // -> UPDATE
    n_cmp++;
    if (pc_en !== 1'b1 || pc_load !== 1'b0 || instr_valid !== 1'b0) begin
      n_err++; $display("FAIL exec_update: en=%b ld=%b v=%b required en=1 ld=0 v=0", pc_en, pc_load, instr_valid);
    end
    tick();                               // -> FETCH
    n_cmp++;
    if (pc_en !== 1'b0 || imem_ren !== 1'b1 || imem_addr !== 5'd1) begin
      n_err++; $display("FAIL exec_next_fetch: en=%b ren=%b addr=%0d required en=0 ren=1 addr=1", pc_en, imem_ren, imem_addr);
    end
    $display("test_execute: op=1 operand=5 issued from pc 0");
  endtask

  task automatic test_stall();
    instr_ready = 1'b0;
    tick(); tick();                       // DECODE -> ISSUE
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (instr_valid !== 1'b1 || instr_opcode !== 3'd2 || instr_operand !== 5'd3 ||
          instr_pc !== 5'd1 || pc_en !== 1'b0 || pc_load !== 1'b0) begin
        n_err++;
        $display("FAIL stall_hold[%0d]: v=%b op=%0d opd=%0d pc=%0d en=%b ld=%b required v=1 op=2 opd=3 pc=1 en=0 ld=0",
                 i, instr_valid, instr_opcode, instr_operand, instr_pc, pc_en, pc_load);
      end
      tick();
    end
    n_cmp++;
    if (instr_valid !== 1'b1) begin
      n_err++; $display("FAIL stall_still_valid: instr_valid=%b required 1", instr_valid);
    end
    instr_ready = 1'b1;
    tick();                               // -> UPDATE
    n_cmp++;
    if (pc_en !== 1'b1 || pc_load !== 1'b0) begin
      n_err++; $display("FAIL stall_update: en=%b ld=%b required en=1 ld=0", pc_en, pc_load);
    end
    tick();                               // -> FETCH
    n_cmp++;
    if (pc_en !== 1'b0 || imem_addr !== 5'd2) begin
      n_err++; $display("FAIL stall_next_fetch: en=%b addr=%0d required en=0 addr=2", pc_en, imem_addr);
    end
    $display("test_stall: op=2 operand=3 held 4 cycles then accepted");
  endtask

  task automatic test_jmp();
    tick();                               // -> DECODE
    tick();                               // -> UPDATE
    n_cmp++;
    if (pc_load !== 1'b1 || pc_data !== 5'd10 || pc_en !== 1'b0 || instr_valid !== 1'b0) begin
      n_err++;
      $display("FAIL jmp_update: ld=%b pd=%0d en=%b v=%b required ld=1 pd=10 en=0 v=0",
               pc_load, pc_data, pc_en, instr_valid);
    end
    tick();                               // -> FETCH
    n_cmp++;
    if (pc_load !== 1'b0 || imem_addr !== 5'd10 || instr_valid !== 1'b0) begin
      n_err++; $display("FAIL jmp_next_fetch: ld=%b addr=%0d v=%b required ld=0 addr=10 v=0", pc_load, imem_addr, instr_valid);
    end
    $display("test_jmp: JMP 10 taken");
  endtask

  task automatic test_jz_not_taken();
    zero_flag = 1'b0;
    tick(); tick();                       // DECODE -> UPDATE
    n_cmp++;
    if (pc_en !== 1'b1 || pc_load !== 1'b0) begin
      n_err++; $display("FAIL jz0_update: en=%b ld=%b required en=1 ld=0", pc_en, pc_load);
    end
    tick();
    n_cmp++;
    if (imem_ren !== 1'b1 || imem_addr !== 5'd11) begin
      n_err++; $display("FAIL jz0_next_fetch: ren=%b addr=%0d required ren=1 addr=11", imem_ren, imem_addr);
    end
    $display("test_jz_not_taken: JZ 20 fell through to 11");
  endtask

  task automatic test_halt();
    tick(); tick();                       // DECODE -> HALT
    n_cmp++;
    if (halted !== 1'b1) begin
      n_err++; $display("FAIL halt_entered: halted=%b required 1", halted);
    end
    for (int i = 0; i < 10; i++) begin
      start = (i % 2 == 0);
      tick();
      n_cmp++;
      if (halted !== 1'b1 || imem_ren !== 1'b0 || pc_en !== 1'b0 || pc_load !== 1'b0) begin
        n_err++;
        $display("FAIL halt_hold[%0d]: h=%b ren=%b en=%b ld=%b required h=1 ren=0 en=0 ld=0",
                 i, halted, imem_ren, pc_en, pc_load);
      end
    end
    start = 1'b0;
    $display("test_halt: halted, start pulses ignored");
  endtask

  task automatic test_jz_taken_and_wrap();
    rst = 1'b0; pc_rst = 1'b1; pc_rst_val = 5'd10;
    tick();
    n_cmp++;
    if (halted !== 1'b0) begin
      n_err++; $display("FAIL rerun_reset_halted: halted=%b required 0", halted);
    end
    rst = 1'b1; pc_rst = 1'b0; zero_flag = 1'b1; instr_ready = 1'b1;
    start = 1'b1;
    tick();                               // -> FETCH 10
    start = 1'b0;
    tick(); tick();                       // DECODE -> UPDATE
    n_cmp++;
    if (pc_load !== 1'b1 || pc_data !== 5'd20 || pc_en !== 1'b0) begin
      n_err++; $display("FAIL jz1_update: ld=%b pd=%0d en=%b required ld=1 pd=20 en=0", pc_load, pc_data, pc_en);
    end
    zero_flag = 1'b0;
    tick(); tick(); tick();               // FETCH 20 (JMP 31) -> DECODE -> UPDATE
    n_cmp++;
    if (pc_load !== 1'b1 || pc_data !== 5'd31) begin
      n_err++; $display("FAIL wrap_jmp31: ld=%b pd=%0d required ld=1 pd=31", pc_load, pc_data);
    end
    tick(); tick(); tick();               // FETCH 31 -> DECODE -> ISSUE
    n_cmp++;
    if (instr_valid !== 1'b1 || instr_opcode !== 3'd1 || instr_operand !== 5'd1 || instr_pc !== 5'd31) begin
      n_err++;
      $display("FAIL wrap_issue: v=%b op=%0d opd=%0d pc=%0d required v=1 op=1 opd=1 pc=31",
               instr_valid, instr_opcode, instr_operand, instr_pc);
    end
    tick();                               // -> UPDATE
    n_cmp++;
    if (pc_en !== 1'b1 || pc_load !== 1'b0) begin
      n_err++; $display("FAIL wrap_update: en=%b ld=%b required en=1 ld=0", pc_en, pc_load);
    end
    instr_ready = 1'b0;
    tick();                               // -> FETCH 0
    n_cmp++;
    if (imem_ren !== 1'b1 || imem_addr !== 5'd0) begin
      n_err++; $display("FAIL wrap_next_fetch: ren=%b addr=%0d required ren=1 addr=0", imem_ren, imem_addr);
    end
    $display("test_jz_taken_and_wrap: JZ 20 taken, JMP 31, wrapped to 0");
  endtask

  task automatic test_reset_mid_issue();
    tick(); tick();                       // DECODE -> ISSUE (ready low)
    n_cmp++;
    if (instr_valid !== 1'b1) begin
      n_err++; $display("FAIL midreset_pre_valid: instr_valid=%b required 1", instr_valid);
    end
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if (instr_valid !== 1'b0 || instr_opcode !== 3'd0) begin
      n_err++; $display("FAIL midreset_async_drop: v=%b op=%0d required v=0 op=0", instr_valid, instr_opcode);
    end
    tick();
    rst = 1'b1;
    instr_ready = 1'b1;                   // ready with no valid must be ignored
    tick(); tick();
    n_cmp++;
    if (imem_ren !== 1'b0 || instr_valid !== 1'b0 || pc_en !== 1'b0) begin
      n_err++; $display("FAIL midreset_idle: ren=%b v=%b en=%b required ren=0 v=0 en=0", imem_ren, instr_valid, pc_en);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    n_cmp++;
    if (imem_ren !== 1'b1 || imem_addr !== 5'd0) begin
      n_err++; $display("FAIL midreset_restart: ren=%b addr=%0d required ren=1 addr=0", imem_ren, imem_addr);
    end
    $display("test_reset_mid_issue: pending instruction discarded, restart from IDLE");
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    mem[0]  = 8'h25;
    mem[1]  = 8'h43;
    mem[2]  = 8'hEA;
    mem[10] = 8'hD4;
    mem[11] = 8'h00;
    mem[20] = 8'hFF;
    mem[31] = 8'h21;
    imem_rdata = '0;
    pc_count = '0;
    test_reset();
    test_execute();
    test_stall();
    test_jmp();
    test_jz_not_taken();
    test_halt();
    test_jz_taken_and_wrap();
    test_reset_mid_issue();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
